// File: rtl/ysyx_040066_mem_arbiter.sv
// Round-robin N-master arbiter feeding one burst read/write slave port.
// Optional watchdog enabled by defining YSYX_040066_ARB_TIMEOUT_EN.
module ysyx_040066_mem_arbiter #(
  parameter int unsigned NUM_M          = 2,
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned LINE_W         = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M-1:0]         m_rd_req,
  input  logic [NUM_M-1:0]         m_rd_burst,
  input  logic [3*NUM_M-1:0]       m_rd_len,
  input  logic [ADDR_W*NUM_M-1:0]  m_rd_addr,
  output logic [NUM_M-1:0]         m_rd_ready,
  output logic [NUM_M-1:0]         m_rd_last,
  output logic [NUM_M-1:0]         m_rd_err,
  output logic [DATA_W-1:0]        m_rd_data,
  input  logic [NUM_M-1:0]         m_wr_req,
  input  logic [NUM_M-1:0]         m_wr_burst,
  input  logic [3*NUM_M-1:0]       m_wr_len,
  input  logic [8*NUM_M-1:0]       m_wr_mask,
  input  logic [ADDR_W*NUM_M-1:0]  m_wr_addr,
  input  logic [LINE_W*NUM_M-1:0]  m_wr_data,
  output logic [NUM_M-1:0]         m_wr_ready,
  output logic [NUM_M-1:0]         m_wr_err,
  output logic                     rd_req,
  output logic                     rd_burst,
  output logic [2:0]               rd_len,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_ready,
  input  logic                     rd_last,
  input  logic                     rd_err,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     wr_req,
  output logic                     wr_burst,
  output logic [2:0]               wr_len,
  output logic [7:0]               wr_mask,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [LINE_W-1:0]        wr_data,
  input  logic                     wr_ready,
  input  logic                     wr_err,
  output logic                     busy,
  output logic [2:0]               grant_id,
  output logic                     proto_err
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state, state_d;
  logic [2:0]  grant, grant_d, ptr, ptr_d;
  logic [3:0]  beats, beats_d;
  logic        timeout;
  logic        in_rd, in_wr;

  logic [NUM_M-1:0]   grant_oh;
  logic               sel_rd_burst, sel_wr_burst;
  logic [2:0]         sel_rd_len, sel_wr_len;
  logic [7:0]         sel_wr_mask;
  logic [ADDR_W-1:0]  sel_rd_addr, sel_wr_addr;
  logic [LINE_W-1:0]  sel_wr_data;

  always_comb begin
    grant_oh     = '0;
    sel_rd_burst = 1'b0;
    sel_rd_len   = '0;
    sel_rd_addr  = '0;
    sel_wr_burst = 1'b0;
    sel_wr_len   = '0;
    sel_wr_mask  = '0;
    sel_wr_addr  = '0;
    sel_wr_data  = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (grant == 3'(i)) begin
        grant_oh[i]  = 1'b1;
        sel_rd_burst = m_rd_burst[i];
        sel_rd_len   = m_rd_len[3*i +: 3];
        sel_rd_addr  = m_rd_addr[ADDR_W*i +: ADDR_W];
        sel_wr_burst = m_wr_burst[i];
        sel_wr_len   = m_wr_len[3*i +: 3];
        sel_wr_mask  = m_wr_mask[8*i +: 8];
        sel_wr_addr  = m_wr_addr[ADDR_W*i +: ADDR_W];
        sel_wr_data  = m_wr_data[LINE_W*i +: LINE_W];
      end
    end
  end

  // Scan a doubled request vector so the wrap past NUM_M-1 needs no runtime modulo.
  logic [2*NUM_M-1:0] cand2;
  logic               found, pick_wr;
  logic [2:0]         pick;

  always_comb begin
    cand2   = {2{m_rd_req | m_wr_req}};
    found   = 1'b0;
    pick    = '0;
    pick_wr = 1'b0;
    for (int unsigned k = 0; k < 2 * NUM_M; k++) begin
      if (!found && cand2[k] && (k > 32'(ptr)) && (k <= 32'(ptr) + NUM_M)) begin
        found   = 1'b1;
        pick    = 3'(k % NUM_M);
        pick_wr = m_wr_req[k % NUM_M];
      end
    end
  end

`ifdef YSYX_040066_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
  logic          resp;

  assign resp    = rd_ready | rd_err | wr_ready | wr_err;
  assign timeout = (state != IDLE) && !resp && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || resp || timeout) timer <= '0;
    else                                         timer <= timer + 1'b1;
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state;
    grant_d = grant;
    ptr_d   = ptr;
    beats_d = beats;
    unique case (state)
      IDLE: begin
        beats_d = '0;
        if (found) begin
          grant_d = pick;
          state_d = pick_wr ? WR : RD;
        end
      end
      RD: begin
        if (rd_ready && beats != 4'hF) beats_d = beats + 4'd1;
        if ((rd_ready && rd_last) || rd_err || timeout) begin
          ptr_d   = grant;
          state_d = IDLE;
        end
      end
      WR: begin
        if (wr_ready || wr_err || timeout) begin
          ptr_d   = grant;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= 3'(NUM_M - 1);
      beats <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      ptr   <= ptr_d;
      beats <= beats_d;
    end
  end

  // Beat being delivered now is beats+1; compare against the length the master asked for.
  logic [4:0] beat_now, beat_exp;
  assign beat_now = {1'b0, beats} + 5'd1;
  assign beat_exp = sel_rd_burst ? ({2'b00, sel_rd_len} + 5'd1) : 5'd1;

  assign in_rd     = (state == RD);
  assign in_wr     = (state == WR);
  assign busy      = (state != IDLE);
  assign grant_id  = grant;
  assign proto_err = in_rd && rd_ready && rd_last && (beat_now != beat_exp);

  assign rd_req   = in_rd;
  assign rd_burst = in_rd & sel_rd_burst;
  assign rd_len   = in_rd ? sel_rd_len  : '0;
  assign rd_addr  = in_rd ? sel_rd_addr : '0;
  assign wr_req   = in_wr;
  assign wr_burst = in_wr & sel_wr_burst;
  assign wr_len   = in_wr ? sel_wr_len  : '0;
  assign wr_mask  = in_wr ? sel_wr_mask : '0;
  assign wr_addr  = in_wr ? sel_wr_addr : '0;
  assign wr_data  = in_wr ? sel_wr_data : '0;

  assign m_rd_ready = (in_rd && rd_ready)            ? grant_oh : '0;
  assign m_rd_last  = (in_rd && rd_ready && rd_last) ? grant_oh : '0;
  assign m_rd_err   = (in_rd && (rd_err || timeout)) ? grant_oh : '0;
  assign m_rd_data  = in_rd ? rd_data : '0;
  assign m_wr_ready = (in_wr && wr_ready)            ? grant_oh : '0;
  assign m_wr_err   = (in_wr && (wr_err || timeout)) ? grant_oh : '0;

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Scoreboard bench for ysyx_040066_mem_arbiter with a scripted slave model.
module tb_ysyx_040066_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    m_rd_req, m_rd_burst = '0, m_rd_ready, m_rd_last, m_rd_err;
  logic [3*N-1:0]  m_rd_len = '0;
  logic [AW*N-1:0] m_rd_addr = '0;
  logic [DW-1:0]   m_rd_data;
  logic [N-1:0]    m_wr_req, m_wr_burst = '0, m_wr_ready, m_wr_err;
  logic [3*N-1:0]  m_wr_len = '0;
  logic [8*N-1:0]  m_wr_mask = '0;
  logic [AW*N-1:0] m_wr_addr = '0;
  logic [LW*N-1:0] m_wr_data = '0;
  logic            rd_req, rd_burst, wr_req, wr_burst, busy, proto_err;
  logic [2:0]      rd_len, wr_len, grant_id;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [7:0]      wr_mask;
  logic [LW-1:0]   wr_data;
  logic            rd_ready = 0, rd_last = 0, rd_err = 0, wr_ready = 0, wr_err = 0;
  logic [DW-1:0]   rd_data = '0;

  ysyx_040066_mem_arbiter #(
    .NUM_M(N), .ADDR_W(AW), .DATA_W(DW), .LINE_W(LW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .m_rd_req(m_rd_req), .m_rd_burst(m_rd_burst), .m_rd_len(m_rd_len), .m_rd_addr(m_rd_addr),
    .m_rd_ready(m_rd_ready), .m_rd_last(m_rd_last), .m_rd_err(m_rd_err), .m_rd_data(m_rd_data),
    .m_wr_req(m_wr_req), .m_wr_burst(m_wr_burst), .m_wr_len(m_wr_len), .m_wr_mask(m_wr_mask),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_ready(m_wr_ready), .m_wr_err(m_wr_err),
    .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_last(rd_last), .rd_err(rd_err), .rd_data(rd_data),
    .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
    .busy(busy), .grant_id(grant_id), .proto_err(proto_err)
  );

  typedef struct {
    int          kind;   // 0 read beat, 1 read err, 2 write ok, 3 write err
    logic [N-1:0] vec;
    logic [N-1:0] last;
    logic [63:0] data;
    logic [63:0] addr;
    logic [LW-1:0] line;
    logic [7:0]  mask;
    logic [3:0]  wctl;
    logic [2:0]  gid;
    logic        perr;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, rdreq_cycles = 0, last_done_cyc = 0, last_gap = 0;
  logic prev_req = 1'b0;

  // Master request lines: raised by the stimulus counters, retired by the monitor counters.
  int rd_iss[N], rd_done[N], wr_iss[N], wr_done[N];
  initial for (int i = 0; i < N; i++) begin rd_iss[i] = 0; rd_done[i] = 0; wr_iss[i] = 0; wr_done[i] = 0; end
  always_comb begin
    m_rd_req = '0;
    m_wr_req = '0;
    for (int i = 0; i < N; i++) begin
      m_rd_req[i] = (rd_iss[i] != rd_done[i]);
      m_wr_req[i] = (wr_iss[i] != wr_done[i]);
    end
  end

  function automatic logic [63:0] pat(input logic [63:0] a, input int b);
    return a + 64'(b) * 64'h0000_0101_0101;
  endfunction

  // Slave script knobs, written only by the stimulus.
  int sl_last_at = 0, sl_err_at = 0;
  bit sl_silent = 0;

  initial begin
    int beat, last_at, err_at;
    bit ract, wact;
    ract = 0; wact = 0; beat = 0; last_at = 0; err_at = 0;
    forever begin
      @(posedge clk); #1;
      rd_ready = 0; rd_last = 0; rd_err = 0; rd_data = '0; wr_ready = 0; wr_err = 0;
      if (rst || sl_silent) begin
        ract = 0; wact = 0;
      end else begin
        if (!rd_req) ract = 0;
        else if (!ract) begin
          ract = 1; beat = 0;
          last_at = (sl_last_at != 0) ? sl_last_at : (rd_burst ? int'(rd_len) + 1 : 1);
          err_at  = sl_err_at;
        end else begin
          beat++;
          if (beat == err_at) begin
            rd_err = 1; ract = 0;
          end else begin
            rd_ready = 1; rd_data = pat(rd_addr, beat);
            if (beat == last_at) begin rd_last = 1; ract = 0; end
          end
        end
        if (!wr_req) wact = 0;
        else if (!wact) wact = 1;
        else begin wr_ready = 1; wact = 0; end
      end
    end
  end

  always @(negedge clk) begin
    ev_t a, e;
    cyc++;
    if (!rst) begin
      if (rd_req) rdreq_cycles++;
      if ((rd_req || wr_req) && !prev_req) last_gap = cyc - last_done_cyc;
      if (|{m_rd_ready, m_rd_err, m_wr_ready, m_wr_err}) begin
        a.kind = (|m_rd_err) ? 1 : (|m_rd_ready) ? 0 : (|m_wr_err) ? 3 : 2;
        a.vec  = (a.kind == 0) ? m_rd_ready : (a.kind == 1) ? m_rd_err :
                 (a.kind == 2) ? m_wr_ready : m_wr_err;
        a.last = m_rd_last;
        a.data = m_rd_data;
        a.addr = (a.kind < 2) ? rd_addr : wr_addr;
        a.line = (a.kind >= 2) ? wr_data : '0;
        a.mask = (a.kind >= 2) ? wr_mask : '0;
        a.wctl = (a.kind >= 2) ? {wr_burst, wr_len} : 4'h0;
        a.gid  = grant_id;
        a.perr = proto_err;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got kind=%0d vec=%b gid=%0d, expected no event", a.kind, a.vec, a.gid);
        end else begin
          e = exp_q.pop_front();
          if (!(a.kind == e.kind && a.vec == e.vec && a.last == e.last && a.data == e.data &&
                a.addr == e.addr && a.line == e.line && a.mask == e.mask && a.wctl == e.wctl &&
                a.gid == e.gid && a.perr == e.perr)) begin
            errors++;
            $display("FAIL event: got kind=%0d vec=%b last=%b data=%h addr=%h mask=%h wctl=%h gid=%0d perr=%b line_ok=%0b, expected kind=%0d vec=%b last=%b data=%h addr=%h mask=%h wctl=%h gid=%0d perr=%b",
                     a.kind, a.vec, a.last, a.data, a.addr, a.mask, a.wctl, a.gid, a.perr, a.line == e.line,
                     e.kind, e.vec, e.last, e.data, e.addr, e.mask, e.wctl, e.gid, e.perr);
          end
        end
        for (int i = 0; i < N; i++) begin
          if (m_rd_err[i] || m_rd_last[i]) rd_done[i] = rd_done[i] + 1;
          if (m_wr_ready[i] || m_wr_err[i]) wr_done[i] = wr_done[i] + 1;
        end
        if (|{m_rd_last, m_rd_err, m_wr_ready, m_wr_err}) last_done_cyc = cyc;
      end else if (proto_err) begin
        checks++; errors++;
        $display("FAIL stray_proto_err: got 1, expected 0");
      end
    end
    prev_req = rd_req | wr_req;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin rd_iss[i] = rd_done[i]; wr_iss[i] = wr_done[i]; end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic issue_rd(input int m, input bit burst, input logic [2:0] len, input logic [63:0] addr);
    m_rd_burst[m] = burst;
    m_rd_len[3*m +: 3] = len;
    m_rd_addr[AW*m +: AW] = addr;
    rd_iss[m] = rd_iss[m] + 1;
  endtask

  task automatic issue_wr(input int m, input logic [7:0] mask, input logic [63:0] addr, input logic [LW-1:0] line);
    m_wr_burst[m] = 1'b1;
    m_wr_len[3*m +: 3] = 3'd7;
    m_wr_mask[8*m +: 8] = mask;
    m_wr_addr[AW*m +: AW] = addr;
    m_wr_data[LW*m +: LW] = line;
    wr_iss[m] = wr_iss[m] + 1;
  endtask

  task automatic exp_beats(input int m, input logic [63:0] addr, input int n, input bit with_last, input bit perr);
    ev_t e;
    for (int b = 1; b <= n; b++) begin
      e.kind = 0; e.vec = N'(1) << m; e.last = (with_last && b == n) ? (N'(1) << m) : '0;
      e.data = pat(addr, b); e.addr = addr; e.line = '0; e.mask = '0; e.wctl = '0;
      e.gid = 3'(m); e.perr = perr && (b == n);
      exp_q.push_back(e);
    end
  endtask

  task automatic exp_rderr(input int m, input logic [63:0] addr);
    ev_t e;
    e.kind = 1; e.vec = N'(1) << m; e.last = '0; e.data = '0; e.addr = addr;
    e.line = '0; e.mask = '0; e.wctl = '0; e.gid = 3'(m); e.perr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic exp_wr(input int m, input logic [63:0] addr, input logic [7:0] mask, input logic [LW-1:0] line);
    ev_t e;
    e.kind = 2; e.vec = N'(1) << m; e.last = '0; e.data = '0; e.addr = addr;
    e.line = line; e.mask = mask; e.wctl = 4'hF; e.gid = 3'(m); e.perr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || (|m_rd_req) || (|m_wr_req)) && n < 500) begin
      tick(); n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s_complete: got %0d pending events after %0d cycles, expected 0", name, exp_q.size(), n);
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start, n;
    logic [LW-1:0] line;
    line = {16{32'hDEAD_BEA5}};

    // Reset state
    do_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_slave_req", 64'({rd_req, wr_req}), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_strobes", 64'({m_rd_ready, m_rd_last, m_rd_err, m_wr_ready, m_wr_err, proto_err}), 64'd0);
    chk("rst_slave_fields", 64'({rd_burst, rd_len, wr_burst, wr_len, wr_mask}), 64'd0);
    chk("rst_addr_data", rd_addr | wr_addr | m_rd_data | wr_data[63:0], 64'd0);

    // Single master, 8-beat burst
    start = rdreq_cycles;
    issue_rd(0, 1'b1, 3'd7, 64'h0000_0000_8000_1000);
    exp_beats(0, 64'h0000_0000_8000_1000, 8, 1'b1, 1'b0);
    wait_done("burst8");
    chk("burst8_rdreq_cycles", 64'(rdreq_cycles - start), 64'd9);
    chk("burst8_idle", 64'({busy, rd_req}), 64'd0);

    // Simultaneous reads after reset: master 0 then master 1
    do_reset();
    issue_rd(0, 1'b1, 3'd1, 64'h0000_0000_8000_2000);
    issue_rd(1, 1'b1, 3'd1, 64'h0000_0000_8000_3000);
    exp_beats(0, 64'h0000_0000_8000_2000, 2, 1'b1, 1'b0);
    exp_beats(1, 64'h0000_0000_8000_3000, 2, 1'b1, 1'b0);
    wait_done("rr_pair");
    chk("rr_pair_gap", 64'(last_gap), 64'd2);

    // Master 1 write and read together: write goes first
    issue_wr(1, 8'hFF, 64'h0000_0000_8000_4000, line);
    issue_rd(1, 1'b0, 3'd0, 64'h0000_0000_8000_5000);
    exp_wr(1, 64'h0000_0000_8000_4000, 8'hFF, line);
    exp_beats(1, 64'h0000_0000_8000_5000, 1, 1'b1, 1'b0);
    wait_done("wr_then_rd");
    chk("wr_then_rd_gap", 64'(last_gap), 64'd2);

    // Short burst: last on beat 2 of 4
    sl_last_at = 2;
    issue_rd(0, 1'b1, 3'd3, 64'h0000_0000_8000_6000);
    exp_beats(0, 64'h0000_0000_8000_6000, 2, 1'b1, 1'b1);
    wait_done("short_burst");
    sl_last_at = 0;
    chk("short_burst_idle", 64'({busy, proto_err}), 64'd0);

    // Error on beat 3 of master 1 while master 0 waits
    sl_err_at = 3;
    issue_rd(0, 1'b0, 3'd0, 64'h0000_0000_8000_7000);
    issue_rd(1, 1'b1, 3'd7, 64'h0000_0000_8000_8000);
    exp_beats(1, 64'h0000_0000_8000_8000, 2, 1'b0, 1'b0);
    exp_rderr(1, 64'h0000_0000_8000_8000);
    exp_beats(0, 64'h0000_0000_8000_7000, 1, 1'b1, 1'b0);
    wait_done("rd_err");
    sl_err_at = 0;

`ifdef YSYX_040066_ARB_TIMEOUT_EN
    // Silent slave: watchdog fires after 16 cycles
    sl_silent = 1;
    start = rdreq_cycles;
    issue_rd(0, 1'b1, 3'd7, 64'h0000_0000_8000_9000);
    exp_rderr(0, 64'h0000_0000_8000_9000);
    wait_done("timeout");
    chk("timeout_rdreq_cycles", 64'(rdreq_cycles - start), 64'd16);
    chk("timeout_idle", 64'({busy, rd_req}), 64'd0);
    sl_silent = 0;
`endif

    // Reset in the middle of a read
    sl_silent = 1;
    issue_rd(1, 1'b1, 3'd3, 64'h0000_0000_8000_A000);
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    chk("midrst_granted", 64'({busy, grant_id}), 64'h9);
    tick(); tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin rd_iss[i] = rd_done[i]; wr_iss[i] = wr_done[i]; end
    tick();
    chk("midrst_busy_req", 64'({busy, rd_req, wr_req}), 64'd0);
    chk("midrst_grant", 64'(grant_id), 64'd0);
    chk("midrst_fields", rd_addr | 64'({rd_burst, rd_len}), 64'd0);
    chk("midrst_strobes", 64'({m_rd_ready, m_rd_last, m_rd_err, m_wr_ready, m_wr_err, proto_err}), 64'd0);
    rst = 1'b0;
    sl_silent = 0;
    tick();
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_040066_mem_arbiter.md
Name: ysyx_040066_mem_arbiter

Overview:
Parametrised N-master bus arbiter. It merges the refill and writeback channels of several caches (icache, dcache, future L2/DMA) onto the single burst-capable external read/write port. Arbitration is round-robin, one outstanding transaction at a time. It replaces the fixed per-cache bus wiring in the SoC top, and adds a beat counter and protocol checking.

Parameters:
NUM_M, 2, number of masters (1..8); index 0 is icache, index 1 is dcache.
ADDR_W, 64, address width.
DATA_W, 64, read beat width.
LINE_W, 512, write line width.
TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
m_rd_req  in  NUM_M  per-master read request; held until the last beat or an error.
m_rd_burst  in  NUM_M  per-master burst flag.
m_rd_len  in  3*NUM_M  per-master beats minus 1.
m_rd_addr  in  ADDR_W*NUM_M  per-master read address.
m_rd_ready  out  NUM_M  beat-valid strobe to the granted master only.
m_rd_last  out  NUM_M  last-beat strobe to the granted master only.
m_rd_err  out  NUM_M  error strobe to the granted master only.
m_rd_data  out  DATA_W  read data, broadcast to all masters.
m_wr_req  in  NUM_M  per-master write request; held until ready or error.
m_wr_burst  in  NUM_M  per-master burst flag.
m_wr_len  in  3*NUM_M  per-master length field.
m_wr_mask  in  8*NUM_M  per-master byte mask.
m_wr_addr  in  ADDR_W*NUM_M  per-master write address.
m_wr_data  in  LINE_W*NUM_M  per-master write line.
m_wr_ready  out  NUM_M  write-complete strobe to the granted master.
m_wr_err  out  NUM_M  write-error strobe to the granted master.
rd_req, rd_burst, rd_len[3], rd_addr[ADDR_W]  out  slave read request.
rd_ready, rd_last, rd_err  in  1 each  slave read response.
rd_data  in  DATA_W  slave read data.
wr_req, wr_burst, wr_len[3], wr_mask[8], wr_addr[ADDR_W], wr_data[LINE_W]  out  slave write request.
wr_ready, wr_err  in  1 each  slave write response.
busy  out  1  a transaction is in flight.
grant_id  out  3  index of the granted master; valid while busy.
proto_err  out  1  one-cycle pulse on a beat-count mismatch.

Behaviour:
- FSM states: IDLE, RD, WR. On reset: state IDLE, every output 0, last-grant pointer = NUM_M-1 (so master 0 wins first), beat counter 0.
- IDLE: candidate vector is m_rd_req | m_wr_req. Choose the first set bit scanning from pointer+1, wrapping modulo NUM_M.
  - If the chosen master has both requests set, the write goes first. This keeps writeback ahead of refill.
  - Grant is registered: slave req rises 1 cycle after the master req. State moves to WR or RD.
  - No candidate: stay in IDLE.
- RD:
  - Slave rd_* fields are muxed combinationally from the granted master. Masters must hold their fields stable while req is high.
  - Each rd_ready: forward m_rd_ready/m_rd_data to the granted master and increment the beat counter.
  - Exit on rd_ready&rd_last or on rd_err: pointer <= grant_id, state to IDLE, slave req drops the following cycle.
  - On rd_last, beat count ≠ len+1 (burst) or ≠ 1 (single): pulse proto_err. The transfer still completes normally.
- WR: forward wr_ready/wr_err to the granted master and exit to IDLE the same way as RD. No beat counting.
- A new grant needs at least 1 IDLE cycle, so back-to-back transactions take completion + 1 cycle.
- A master dropping req mid-transaction is a protocol violation. The arbiter still waits for slave completion, and the responses go to that master's index.
- Non-granted masters always see ready/last/err = 0.
- rst asserted mid-transaction: immediate return to IDLE with all outputs 0. The slave must also be reset.
- NUM_M=1: the grant is always 0, with the same IDLE-cycle timing.

Optional Feature:
YSYX_040066_ARB_TIMEOUT_EN
- Defined: a cycle counter runs in RD/WR and clears on each slave response. On reaching TIMEOUT_CYCLES, pulse m_rd_err or m_wr_err to the granted master, drop the slave req, and go to IDLE.
- Undefined: no counter; the arbiter waits forever.

Test Plan:
- Single master, m_rd_req[0]=1, burst, len=7; slave returns 8 beats with last on beat 8 -> 8 m_rd_ready[0] pulses, rd_req high 9 cycles, back to IDLE, proto_err=0.
- Masters 0 and 1 request reads in the same cycle after reset -> master 0 granted first, master 1 granted 1 cycle after master 0 completes; grant_id goes 0 then 1.
- Master 1 raises m_wr_req and m_rd_req together, mask 8'hFF, data 512'h…A5 -> wr_req issued first with matching data; after wr_ready, the read is granted.
- Burst read len=3, slave asserts rd_last on beat 2 -> proto_err pulses 1 cycle, master gets last, FSM returns to IDLE.
- rd_err on beat 3 of a len=7 burst -> m_rd_err pulses to the granted master only, transfer ends, other masters unaffected.
- With the macro defined and TIMEOUT_CYCLES=16, slave never responds -> m_rd_err pulses at cycle 16, rd_req drops, busy=0. Separately, rst during RD -> all outputs 0 the next cycle.
